// File: rtl/if_id_buf_pkg.sv
// Shared widths, constants and entry type for the fetch-to-decode buffer.
// Holds the instruction/address widths, the canonical NOP and the fill-state helper.
// Imported by if_id_buf; no logic of its own.
package if_id_buf_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  // ADDI x0,x0,0: keeps the decoder fed with a legal instruction when nothing is buffered
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0]      inst;
    logic [INST_ADDR_W-1:0] addr;
  } ifid_entry_t;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_e;

  // Occupancy class derived purely from the entry count
  function automatic fill_e fill_state(input int cnt, input int depth);
    if (cnt == 0) begin
      return FILL_EMPTY;
    end else if (cnt >= depth) begin
      return FILL_FULL;
    end else begin
      return FILL_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/if_id_buf.sv
// Purpose: fetch-to-decode instruction FIFO of {inst, inst_addr}; NOP on empty, flush on ex jump.
// Latency: 1 cycle push-to-head, no empty bypass; optional IF_ID_BUBBLE_CNT_EN adds starvation counter.
// Backpressure: inst_ready_o drops when full (count only, no pop bypass); id side sees inst_valid_o.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = NOP_WORD
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [INST_W-1:0]      inst_i,
  input  logic [INST_ADDR_W-1:0] inst_addr_i,
  input  logic                   inst_valid_i,
  output logic                   inst_ready_o,
  input  logic                   id_ready_i,
  input  logic                   ex_jump_ena_i,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_ADDR_W-1:0] inst_addr_o,
  output logic                   inst_valid_o,
  output logic [31:0]            bubble_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;

  ifid_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  fill_e            fill;
  logic             push;
  logic             pop;
  ifid_entry_t      head;

  assign fill         = fill_state(int'(count), DEPTH);
  assign inst_ready_o = (fill != FILL_FULL);
  assign inst_valid_o = (fill != FILL_EMPTY);

  // A taken jump wins over both handshakes so nothing stale slips through
  assign push = inst_valid_i & inst_ready_o & ~ex_jump_ena_i;
  assign pop  = id_ready_i & inst_valid_o & ~ex_jump_ena_i;

  assign head        = mem[rd_ptr];
  assign inst_o      = inst_valid_o ? head.inst : NOP_INST;
  assign inst_addr_o = inst_valid_o ? head.addr : ZERO_WORD;

  // Entry storage; contents are left unreset because count masks stale slots
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{inst: inst_i, addr: inst_addr_i};
    end
  end

  // Pointer and occupancy update: flush clears, push/pop advance independently
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ex_jump_ena_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;

  // Count cycles where decode wanted work but the buffer had none; saturating
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bubble_cnt <= '0;
    end else if (id_ready_i && !inst_valid_o && !ex_jump_ena_i && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = bubble_cnt;
`else
  assign bubble_cnt_o = ZERO_WORD;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer.
module tb_if_id_buf;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        arst_n;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic        id_ready_i;
  logic        ex_jump_ena_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [31:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  if_id_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .id_ready_i   (id_ready_i),
    .ex_jump_ena_i(ex_jump_ena_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] adr,
                       input logic rdy, input logic jmp);
    inst_valid_i  = v;
    inst_i        = ins;
    inst_addr_i   = adr;
    id_ready_i    = rdy;
    ex_jump_ena_i = jmp;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    arst_n = 1'b0;
    #3;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", inst_ready_o); end
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", inst_addr_o); end
    checks++; if (bubble_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_bubble: got %h want 0", bubble_cnt_o); end
    step();
    arst_n = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    step();
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", inst_valid_o); end
    // Asynchronous reset in the middle of a transfer
    arst_n = 1'b0;
    #2;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", inst_valid_o); end
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", inst_ready_o); end
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL midreset_inst: got %h want %h", inst_o, NOP); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL midreset_addr: got %h want 0", inst_addr_o); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    drive(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    step();
    checks++; if (inst_o !== 32'h0050_0093) begin errors++; $display("FAIL fill1_inst: got %h want 00500093", inst_o); end
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL fill1_ready: got %b want 1", inst_ready_o); end
    drive(1'b1, 32'h00A0_0113, 32'h4, 1'b0, 1'b0);
    step();
    checks++; if (inst_ready_o !== 1'b0) begin errors++; $display("FAIL fill2_ready: got %b want 0", inst_ready_o); end
    checks++; if (inst_o !== 32'h0050_0093) begin errors++; $display("FAIL fill2_inst: got %h want 00500093", inst_o); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL fill2_addr: got %h want 0", inst_addr_o); end
  endtask

  task automatic test_full_pop();
    // Full: pop happens, offered input is refused
    drive(1'b1, 32'h0000_0193, 32'h8, 1'b1, 1'b0);
    step();
    checks++; if (inst_o !== 32'h00A0_0113) begin errors++; $display("FAIL fullpop_inst: got %h want 00a00113", inst_o); end
    checks++; if (inst_addr_o !== 32'h4) begin errors++; $display("FAIL fullpop_addr: got %h want 4", inst_addr_o); end
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL fullpop_ready: got %b want 1", inst_ready_o); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fullpop_drop_valid: got %b want 0", inst_valid_o); end
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL fullpop_drop_inst: got %h want %h", inst_o, NOP); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'h1111_0013, 32'h100, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h2222_0013, 32'h104, 1'b1, 1'b0);
    step();
    checks++; if (inst_o !== 32'h2222_0013) begin errors++; $display("FAIL wrap1_inst: got %h want 22220013", inst_o); end
    checks++; if (inst_ready_o !== 1'b1 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL wrap1_count: got rdy=%b vld=%b want 1/1", inst_ready_o, inst_valid_o); end
    drive(1'b1, 32'h3333_0013, 32'h108, 1'b1, 1'b0);
    step();
    checks++; if (inst_o !== 32'h3333_0013 || inst_addr_o !== 32'h108) begin errors++; $display("FAIL wrap2_head: got %h@%h want 33330013@108", inst_o, inst_addr_o); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b want 0", inst_valid_o); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hAAAA_0013, 32'h200, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hBBBB_0013, 32'h204, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hCCCC_0013, 32'h208, 1'b1, 1'b1);
    step();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", inst_valid_o); end
    checks++; if (inst_o !== NOP || inst_addr_o !== 32'h0) begin errors++; $display("FAIL flush_nop: got %h@%h want %h@0", inst_o, inst_addr_o, NOP); end
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", inst_ready_o); end
    drive(1'b1, 32'hDDDD_0013, 32'h400, 1'b0, 1'b0);
    step();
    checks++; if (inst_o !== 32'hDDDD_0013 || inst_addr_o !== 32'h400) begin errors++; $display("FAIL flush_target: got %h@%h want dddd0013@400", inst_o, inst_addr_o); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drain: got %b want 0", inst_valid_o); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_bubble();
    logic [31:0] exp5;
`ifdef IF_ID_BUBBLE_CNT_EN
    exp5 = 32'd5;
`else
    exp5 = 32'd0;
`endif
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (5) step();
    checks++; if (bubble_cnt_o !== exp5) begin errors++; $display("FAIL bubble_five: got %0d want %0d", bubble_cnt_o, exp5); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    checks++; if (bubble_cnt_o !== exp5) begin errors++; $display("FAIL bubble_jump_hold: got %0d want %0d", bubble_cnt_o, exp5); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] bub;
    logic [31:0] exp_inst, exp_addr;
    logic        exp_vld, exp_rdy;
    logic        v, r, j;
    logic [31:0] ri, ra;
    int          pre;
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    bub = 32'h0;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 6);
      j  = ($urandom_range(0, 19) == 0);
      ri = $urandom;
      ra = $urandom & 32'hFFFF_FFFC;
      drive(v, ri, ra, r, j);
      pre = q.size();
      if (j) begin
        q.delete();
      end else begin
        if (r && pre > 0) void'(q.pop_front());
        if (v && pre < DEPTH) q.push_back({ri, ra});
      end
`ifdef IF_ID_BUBBLE_CNT_EN
      if (r && pre == 0 && !j && bub != 32'hFFFF_FFFF) bub = bub + 32'd1;
`endif
      step();
      exp_vld  = (q.size() > 0);
      exp_rdy  = (q.size() < DEPTH);
      exp_inst = exp_vld ? q[0][63:32] : NOP;
      exp_addr = exp_vld ? q[0][31:0]  : 32'h0;
      checks++;
      if ({inst_valid_o, inst_ready_o, inst_o, inst_addr_o} !== {exp_vld, exp_rdy, exp_inst, exp_addr}) begin
        errors++;
        $display("FAIL rand_cycle%0d: got vld=%b rdy=%b %h@%h want vld=%b rdy=%b %h@%h",
                 n, inst_valid_o, inst_ready_o, inst_o, inst_addr_o, exp_vld, exp_rdy, exp_inst, exp_addr);
      end
      checks++;
      if (bubble_cnt_o !== bub) begin
        errors++;
        $display("FAIL rand_bubble%0d: got %0d want %0d", n, bubble_cnt_o, bub);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    arst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_fill();
    test_full_pop();
    test_wrap();
    test_flush();
    test_bubble();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
